// File: rtl/alu_z_stage.sv
// Z-stage ALU: eight operations on the shifted Y operand and the bus operand,
// with single-cycle logic/arithmetic ops and an iterative shift-add multiply.
module alu_z_stage #(
    parameter int WIDTH     = 16,
    parameter int MUL_STEPS = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] Y_shifted,
    input  logic [WIDTH-1:0] from_bus,
    input  logic [2:0]       alu_op,
    input  logic             alu_start,
    output logic             alu_busy,
    output logic             alu_done,
    output logic [WIDTH-1:0] Z_out,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v
);

    localparam int CNT_W = (MUL_STEPS > 2) ? $clog2(MUL_STEPS) : 1;
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
    localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_STEPS - 1);

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_NOT  = 3'd5;
    localparam logic [2:0] OP_PASS = 3'd6;
    localparam logic [2:0] OP_MUL  = 3'd7;

    typedef enum logic {
        IDLE    = 1'b0,
        MUL_RUN = 1'b1
    } state_t;

    state_t             state_r;
    logic [WIDTH-1:0]   mcand_r;
    logic [WIDTH-1:0]   mplier_r;
    logic [WIDTH-1:0]   acc_r;
    logic [CNT_W-1:0]   count_r;

    logic [WIDTH-1:0]   res_s;
    logic               c_s;
    logic               v_s;
    logic [WIDTH:0]     sum_s;
    logic [WIDTH-1:0]   diff_s;
    logic [WIDTH-1:0]   acc_next_s;

    // Single-cycle result and carry/overflow for the operation on the inputs.
    always_comb begin
        res_s  = ZERO_W;
        c_s    = 1'b0;
        v_s    = 1'b0;
        sum_s  = {1'b0, Y_shifted} + {1'b0, from_bus};
        diff_s = Y_shifted - from_bus;
        case (alu_op)
            OP_ADD: begin
                res_s = sum_s[WIDTH-1:0];
                c_s   = sum_s[WIDTH];
                v_s   = (Y_shifted[WIDTH-1] == from_bus[WIDTH-1]) &&
                        (sum_s[WIDTH-1] != Y_shifted[WIDTH-1]);
            end
            OP_SUB: begin
                res_s = diff_s;
                c_s   = (Y_shifted >= from_bus);
                v_s   = (Y_shifted[WIDTH-1] != from_bus[WIDTH-1]) &&
                        (diff_s[WIDTH-1] != Y_shifted[WIDTH-1]);
            end
            OP_AND:  res_s = Y_shifted & from_bus;
            OP_OR:   res_s = Y_shifted | from_bus;
            OP_XOR:  res_s = Y_shifted ^ from_bus;
            OP_NOT:  res_s = ~Y_shifted;
            OP_PASS: res_s = Y_shifted;
            default: res_s = ZERO_W;
        endcase
    end

    // One shift-add step of the multiplier.
    always_comb begin
        if (mplier_r[0]) begin
            acc_next_s = acc_r + mcand_r;
        end else begin
            acc_next_s = acc_r;
        end
    end

    // Control FSM, multiply datapath and registered Z/flag outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r  <= IDLE;
            mcand_r  <= ZERO_W;
            mplier_r <= ZERO_W;
            acc_r    <= ZERO_W;
            count_r  <= ZERO_CNT;
            Z_out    <= ZERO_W;
            flag_n   <= 1'b0;
            flag_z   <= 1'b0;
            flag_c   <= 1'b0;
            flag_v   <= 1'b0;
            alu_done <= 1'b0;
            alu_busy <= 1'b0;
        end else begin
            alu_done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (alu_start) begin
                        if (alu_op == OP_MUL) begin
                            mcand_r  <= Y_shifted;
                            mplier_r <= from_bus;
                            acc_r    <= ZERO_W;
                            count_r  <= ZERO_CNT;
                            alu_busy <= 1'b1;
                            state_r  <= MUL_RUN;
                        end else begin
                            Z_out    <= res_s;
                            flag_n   <= res_s[WIDTH-1];
                            flag_z   <= (res_s == ZERO_W);
                            flag_c   <= c_s;
                            flag_v   <= v_s;
                            alu_done <= 1'b1;
                        end
                    end
                end
                MUL_RUN: begin
                    acc_r    <= acc_next_s;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    count_r  <= count_r + 1'b1;
                    // Operand inputs and alu_start are deliberately ignored here.
                    if (count_r == LAST_CNT) begin
                        Z_out    <= acc_next_s;
                        flag_n   <= acc_next_s[WIDTH-1];
                        flag_z   <= (acc_next_s == ZERO_W);
                        flag_c   <= 1'b0;
                        flag_v   <= 1'b0;
                        alu_done <= 1'b1;
                        alu_busy <= 1'b0;
                        state_r  <= IDLE;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    alu_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_z_stage.sv
// Directed self-checking bench for alu_z_stage using immediate assertions.
module tb_alu_z_stage;

    logic        clk;
    logic        reset_n;
    logic [15:0] Y_shifted;
    logic [15:0] from_bus;
    logic [2:0]  alu_op;
    logic        alu_start;
    logic        alu_busy;
    logic        alu_done;
    logic [15:0] Z_out;
    logic        flag_n, flag_z, flag_c, flag_v;

    int compared   = 0;
    int mismatched = 0;

    alu_z_stage #(.WIDTH(16), .MUL_STEPS(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .Y_shifted (Y_shifted),
        .from_bus  (from_bus),
        .alu_op    (alu_op),
        .alu_start (alu_start),
        .alu_busy  (alu_busy),
        .alu_done  (alu_done),
        .Z_out     (Z_out),
        .flag_n    (flag_n),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .flag_v    (flag_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // flags packed as {n,z,c,v}
    task automatic chk_flags(input string tag, input logic [3:0] exp);
        chk(tag, {12'h000, flag_n, flag_z, flag_c, flag_v}, {12'h000, exp});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        alu_op    = op;
        Y_shifted = a;
        from_bus  = b;
        alu_start = 1'b1;
        step();
        alu_start = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        Y_shifted = 16'h0000;
        from_bus  = 16'h0000;
        alu_op    = 3'd0;
        alu_start = 1'b0;
        step();
        step();
        chk("rst_z", Z_out, 16'h0000);
        chk_flags("rst_flags", 4'b0000);
        chk("rst_done_busy", {14'h0, alu_done, alu_busy}, 16'h0000);
        reset_n = 1'b1;
        step();

        // ADD signed overflow
        issue(3'd0, 16'h7FFF, 16'h0001);
        chk("add_z", Z_out, 16'h8000);
        chk_flags("add_flags", 4'b1001);
        chk("add_done", {15'h0, alu_done}, 16'h0001);
        step();
        chk("add_done_drop", {15'h0, alu_done}, 16'h0000);
        chk("add_hold", Z_out, 16'h8000);

        // ADD unsigned carry to zero
        issue(3'd0, 16'hFFFF, 16'h0001);
        chk("addc_z", Z_out, 16'h0000);
        chk_flags("addc_flags", 4'b0110);

        // SUB with borrow, then equal operands
        issue(3'd1, 16'h0003, 16'h0005);
        chk("sub1_z", Z_out, 16'hFFFE);
        chk_flags("sub1_flags", 4'b1000);
        issue(3'd1, 16'h0005, 16'h0005);
        chk("sub2_z", Z_out, 16'h0000);
        chk_flags("sub2_flags", 4'b0110);
        // SUB signed overflow: 0x8000 - 1 = 0x7FFF
        issue(3'd1, 16'h8000, 16'h0001);
        chk("sub3_z", Z_out, 16'h7FFF);
        chk_flags("sub3_flags", 4'b0011);
        issue(3'd2, 16'h1234, 16'h0000);
        chk("and_z", Z_out, 16'h0000);
        chk_flags("and_flags", 4'b0100);
        step();

        // MUL 0x12 * 0x34 = 0x3A8; operands wiggle during run
        issue(3'd7, 16'h0012, 16'h0034);
        chk("mul1_busy0", {15'h0, alu_busy}, 16'h0001);
        chk("mul1_done0", {15'h0, alu_done}, 16'h0000);
        for (int i = 1; i < 16; i++) begin
            Y_shifted = 16'($urandom);
            from_bus  = 16'($urandom);
            step();
            chk("mul1_busy", {15'h0, alu_busy}, 16'h0001);
            chk("mul1_done_early", {15'h0, alu_done}, 16'h0000);
            chk("mul1_z_hold", Z_out, 16'h0000);
        end
        step();
        chk("mul1_done", {15'h0, alu_done}, 16'h0001);
        chk("mul1_busy_end", {15'h0, alu_busy}, 16'h0000);
        chk("mul1_z", Z_out, 16'h03A8);
        chk_flags("mul1_flags", 4'b0000);
        step();
        chk("mul1_done_drop", {15'h0, alu_done}, 16'h0000);

        // MUL truncation with an ignored ADD start mid-run
        issue(3'd7, 16'h0100, 16'h0100);
        for (int i = 1; i < 16; i++) begin
            if (i == 5) begin
                alu_op    = 3'd0;
                Y_shifted = 16'h0001;
                from_bus  = 16'h0001;
                alu_start = 1'b1;
            end else begin
                alu_start = 1'b0;
            end
            step();
            chk("mul2_done_early", {15'h0, alu_done}, 16'h0000);
            chk("mul2_z_hold", Z_out, 16'h03A8);
        end
        alu_start = 1'b0;
        step();
        chk("mul2_done", {15'h0, alu_done}, 16'h0001);
        chk("mul2_z", Z_out, 16'h0000);
        chk_flags("mul2_flags", 4'b0100);
        step();
        chk("mul2_no_extra", {15'h0, alu_done}, 16'h0000);
        chk("mul2_z_hold_after", Z_out, 16'h0000);

        // Reset mid-multiply
        issue(3'd0, 16'h1111, 16'h1111);
        chk("pre_z", Z_out, 16'h2222);
        issue(3'd7, 16'h00FF, 16'h00FF);
        for (int i = 1; i < 8; i++) step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("mrst_z", Z_out, 16'h0000);
        chk_flags("mrst_flags", 4'b0000);
        chk("mrst_done_busy", {14'h0, alu_done, alu_busy}, 16'h0000);
        for (int i = 0; i < 12; i++) begin
            step();
            chk("mrst_no_done", {14'h0, alu_done, alu_busy}, 16'h0000);
        end
        issue(3'd0, 16'h0001, 16'h0002);
        chk("post_add_z", Z_out, 16'h0003);
        chk("post_add_done", {15'h0, alu_done}, 16'h0001);
        chk_flags("post_add_flags", 4'b0000);

        // Back-to-back single-cycle ops
        alu_op = 3'd4; Y_shifted = 16'hF0F0; from_bus = 16'hFF00; alu_start = 1'b1;
        step();
        chk("b2b_xor_z", Z_out, 16'h0FF0);
        chk("b2b_xor_done", {15'h0, alu_done}, 16'h0001);
        alu_op = 3'd5; Y_shifted = 16'h00FF; from_bus = 16'h0000;
        step();
        alu_start = 1'b0;
        chk("b2b_not_z", Z_out, 16'hFF00);
        chk("b2b_not_done", {15'h0, alu_done}, 16'h0001);
        chk_flags("b2b_not_flags", 4'b1000);
        issue(3'd6, 16'hA5A5, 16'h0000);
        chk("pass_z", Z_out, 16'hA5A5);
        issue(3'd3, 16'h0F00, 16'h00F0);
        chk("or_z", Z_out, 16'h0FF0);
        step();
        chk("b2b_done_drop", {15'h0, alu_done}, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
